// File: rtl/heichips25_spi_cfg_target.sv
// heichips25_spi_cfg_target
// SPI mode-0 target that accepts a configuration bitstream from an external
// host. SPI pins are oversampled in the fabric clock domain. A one-byte
// command selects WRITE (0x01), which packs mosi into MSB-first words and
// queues them for the config loader through a small FIFO.
// Optional feature macro: SPI_CFG_STATUS_READ_EN enables the STATUS command
// (0x05), which shifts a status byte out on miso. Without it, 0x05 is ignored,
// miso/miso_en are tied low, and overflow/partial clear only on reset.
module heichips25_spi_cfg_target #(
  parameter int WORD_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              fpga_clk_i,
  input  logic              fpga_rst_ni,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_en_o,
  output logic [WORD_W-1:0] cfg_word_o,
  output logic              cfg_valid_o,
  input  logic              cfg_ready_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [15:0]       word_count_o
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]       CMD_WRITE     = 8'h01;
`ifdef SPI_CFG_STATUS_READ_EN
  localparam logic [7:0]       CMD_STATUS    = 8'h05;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WRITE  = 3'd2,
    ST_STATUS = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  // Word counter increments saturate instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_p0, cs_p0, mosi_p0;
  logic                   sclk_d, cs_d;
  logic                   sclk_rise_p1, cs_fall_p1, cs_rise_p1, mosi_p1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [WORD_W-2:0]      shift_q;
  logic [WORD_W-1:0]      word_in;
  logic [7:0]             cmd_byte;

  logic                   shift_en, cmd_done, enter_write, push_req;
  logic                   partial_set, status_clr;

  logic [WORD_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         fifo_cnt_q;
  logic                   fifo_empty, fifo_full, pop, accept;

  logic                   busy_q, overflow_q, partial_q;
  logic [15:0]            word_cnt_q;

  // ---- stage p0: synchronized pin levels
  // Control pins pass through a reset synchronizer chain; cs_n idles high.
  always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
    if (!fpga_rst_ni) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
    end
  end

  // mosi is pure data and needs no reset.
  always_ff @(posedge fpga_clk_i) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
    mosi_p1   <= mosi_p0;
  end

  assign sclk_p0 = sclk_sync[SYNC_STAGES-1];
  assign cs_p0   = cs_sync[SYNC_STAGES-1];
  assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

  // ---- stage p1: registered edge pulses that drive the FSM
  // Previous-level registers plus the registered edge pulses.
  always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
    if (!fpga_rst_ni) begin
      sclk_d       <= 1'b0;
      cs_d         <= 1'b1;
      sclk_rise_p1 <= 1'b0;
      cs_fall_p1   <= 1'b0;
      cs_rise_p1   <= 1'b0;
    end else begin
      sclk_d       <= sclk_p0;
      cs_d         <= cs_p0;
      sclk_rise_p1 <= sclk_p0 & ~sclk_d;
      cs_fall_p1   <= ~cs_p0 & cs_d;
      cs_rise_p1   <= cs_p0 & ~cs_d;
    end
  end

  assign word_in  = {shift_q, mosi_p1};
  assign cmd_byte = {shift_q[6:0], mosi_p1};

  // FSM state register.
  always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
    if (!fpga_rst_ni) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // FSM next-state: cs_n rise always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (cs_rise_p1) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall_p1) state_d = ST_CMD;
        ST_CMD: begin
          if (cmd_done) begin
            if (cmd_byte == CMD_WRITE) state_d = ST_WRITE;
`ifdef SPI_CFG_STATUS_READ_EN
            else if (cmd_byte == CMD_STATUS) state_d = ST_STATUS;
`endif
            else state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM outputs: per-cycle datapath strobes decoded from the current state.
  always_comb begin
    shift_en    = 1'b0;
    cmd_done    = 1'b0;
    enter_write = 1'b0;
    push_req    = 1'b0;
    partial_set = 1'b0;
    status_clr  = 1'b0;
    case (state_q)
      ST_CMD: begin
        shift_en    = sclk_rise_p1;
        cmd_done    = sclk_rise_p1 && !cs_rise_p1 && (bit_cnt_q == CNT_CMD_LAST);
        enter_write = cmd_done && (cmd_byte == CMD_WRITE);
      end
      ST_WRITE: begin
        shift_en    = sclk_rise_p1;
        push_req    = sclk_rise_p1 && (bit_cnt_q == CNT_WORD_LAST);
        partial_set = cs_rise_p1 && (bit_cnt_q != '0);
      end
`ifdef SPI_CFG_STATUS_READ_EN
      ST_STATUS: status_clr = cs_rise_p1;
`endif
      default: ;
    endcase
  end

  // Bit counter: cleared in IDLE and on command decode, wraps per word in WRITE.
  always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
    if (!fpga_rst_ni) begin
      bit_cnt_q <= '0;
    end else if (state_q == ST_IDLE || cmd_done) begin
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      bit_cnt_q <= push_req ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  // Input shift register holds the previous WORD_W-1 bits; data only, no reset.
  always_ff @(posedge fpga_clk_i) begin
    if (shift_en) shift_q <= word_in[WORD_W-2:0];
  end

  // ---- FIFO: a push into a full FIFO is still taken when a pop frees a slot
  assign fifo_empty  = (fifo_cnt_q == '0);
  assign fifo_full   = (fifo_cnt_q == FIFO_FULL_CNT);
  assign cfg_valid_o = ~fifo_empty;
  assign cfg_word_o  = fifo_empty ? '0 : mem[rd_ptr_q];
  assign pop         = cfg_valid_o & cfg_ready_i;
  assign accept      = push_req & (~fifo_full | pop);

  // FIFO pointers and occupancy.
  always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
    if (!fpga_rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({accept, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are masked by the empty flag, so no reset needed.
  always_ff @(posedge fpga_clk_i) begin
    if (accept) mem[wr_ptr_q] <= word_in;
  end

  // Status flags and accepted-word counter.
  always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
    if (!fpga_rst_ni) begin
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      partial_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      if (enter_write)                             busy_q <= 1'b1;
      else if (state_q != ST_WRITE && fifo_empty)  busy_q <= 1'b0;

      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
      else if (status_clr)               overflow_q <= 1'b0;

      if (partial_set)     partial_q <= 1'b1;
      else if (status_clr) partial_q <= 1'b0;

      if (enter_write) word_cnt_q <= '0;
      else if (accept) word_cnt_q <= sat_inc16(word_cnt_q);
    end
  end

  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;
  assign word_count_o = word_cnt_q;

`ifdef SPI_CFG_STATUS_READ_EN
  // miso timing uses the unregistered edges so each bit settles a cycle sooner.
  logic       sclk_fall_c, cs_rise_c, enter_status;
  logic [7:0] status_byte, st_sh_q;
  logic       st_skip_q, miso_q, miso_en_q;

  assign sclk_fall_c  = ~sclk_p0 & sclk_d;
  assign cs_rise_c    = cs_p0 & ~cs_d;
  assign enter_status = cmd_done && (cmd_byte == CMD_STATUS);
  assign status_byte  = {busy_q, overflow_q, partial_q, fifo_full, fifo_empty, 3'b000};

  // Status shifter: bit 7 is loaded on entry; the sclk fall that ends the
  // command byte is skipped so the host samples bit 7 on its next rise.
  always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
    if (!fpga_rst_ni) begin
      st_sh_q   <= '0;
      st_skip_q <= 1'b0;
      miso_q    <= 1'b0;
      miso_en_q <= 1'b0;
    end else if (enter_status) begin
      st_sh_q   <= {status_byte[6:0], 1'b0};
      st_skip_q <= 1'b1;
      miso_q    <= status_byte[7];
      miso_en_q <= 1'b1;
    end else if (cs_rise_c || state_q != ST_STATUS) begin
      st_skip_q <= 1'b0;
      miso_q    <= 1'b0;
      miso_en_q <= 1'b0;
    end else if (sclk_fall_c) begin
      if (st_skip_q) begin
        st_skip_q <= 1'b0;
      end else begin
        miso_q  <= st_sh_q[7];
        st_sh_q <= {st_sh_q[6:0], 1'b0};
      end
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_en_o = miso_en_q;
`else
  assign spi_miso_o    = 1'b0;
  assign spi_miso_en_o = 1'b0;
`endif

endmodule
